// File: rtl/biquad_pkg.sv
// Shared types and constants for the multi-channel biquad section and its helpers.
package biquad_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        WB   = 2'd2
    } state_e;

    // Coefficient index doubles as the MAC step counter.
    typedef enum logic [2:0] {
        B0 = 3'd0,
        B1 = 3'd1,
        B2 = 3'd2,
        A1 = 3'd3,
        A2 = 3'd4
    } coef_idx_e;

    localparam int     NCOEF    = 5;
    localparam int     DEF_FRAC = 14;
    localparam longint ONE      = longint'(1) << DEF_FRAC;

    function automatic longint one_of(input int frac);
        return longint'(1) << frac;
    endfunction

    // Reset bank is a unity passthrough: b0 = 1.0, everything else 0.
    function automatic longint reset_coef(input int idx, input int frac);
        return (idx == int'(B0)) ? one_of(frac) : 64'sd0;
    endfunction

endpackage

// File: rtl/biquad_round_sat.sv
// Round-half-up, drop FRAC fractional bits and clip an accumulator to a DATA_W sample.
module biquad_round_sat #(
    parameter int ACC_W  = 48,
    parameter int DATA_W = 16,
    parameter int FRAC   = 14
) (
    input  logic signed [ACC_W-1:0]  acc_i,
    output logic signed [DATA_W-1:0] data_o,
    output logic                     sat_o
);

    localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1) <<< (FRAC - 1);

    logic signed [ACC_W-1:0]      rounded;
    logic signed [ACC_W-1:0]      shifted;
    logic        [ACC_W-DATA_W:0] upper;
    logic                         fits;

    assign rounded = acc_i + HALF;
    assign shifted = rounded >>> FRAC;

    // The value fits when every bit above the sample's sign bit copies it.
    assign upper = shifted[ACC_W-1:DATA_W-1];
    assign fits  = (&upper) | (~|upper);

    always_comb begin
        data_o = shifted[DATA_W-1:0];
        sat_o  = 1'b0;
        if (!fits) begin
            sat_o  = 1'b1;
            data_o = shifted[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                      : {1'b0, {(DATA_W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/biquad_iir_mc.sv
// Multi-channel direct-form-I biquad with one shared multiplier, 7 cycles per sample,
// double-buffered runtime coefficients and per-channel history.
module biquad_iir_mc
    import biquad_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int COEFF_W = 18,
    parameter int FRAC    = 14,
    parameter int ACC_W   = 48,
    parameter int NCH     = 2,
    localparam int CH_W   = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [CH_W-1:0]           in_ch,
    input  logic signed [DATA_W-1:0]  in_data,
    output logic                      out_valid,
    output logic [CH_W-1:0]           out_ch,
    output logic signed [DATA_W-1:0]  out_data,
    output logic                      out_sat,
    input  logic                      coef_we,
    input  logic [2:0]                coef_addr,
    input  logic signed [COEFF_W-1:0] coef_data,
    input  logic                      coef_commit,
    input  logic                      clear
);

    localparam int PROD_W = DATA_W + COEFF_W;

    typedef logic signed [DATA_W-1:0]  samp_t;
    typedef logic signed [COEFF_W-1:0] coef_t;

    state_e                  state_q;
    coef_idx_e               k_q;
    logic [CH_W-1:0]         ch_q;
    samp_t                   x0_q;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_d;

    samp_t x1_q [NCH];
    samp_t x2_q [NCH];
    samp_t y1_q [NCH];
    samp_t y2_q [NCH];

    coef_t shadow_q [NCOEF];
    coef_t shadow_d [NCOEF];
    coef_t active_q [NCOEF];
    logic  pending_q;
    logic  commit_now;

    logic            out_valid_q;
    logic [CH_W-1:0] out_ch_q;
    samp_t           out_data_q;
    logic            out_sat_q;

    logic            accept;
    logic            ch_ok;
    logic [CH_W-1:0] ch_idx;

    samp_t                    op;
    coef_t                    cf;
    logic                     neg;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_ext;

    samp_t rs_data;
    logic  rs_sat;

    assign in_ready = reset_n && (state_q == IDLE) && !clear;
    assign accept   = in_valid && in_ready;

    // Out-of-range channels still run the full sequence but touch no history.
    assign ch_ok  = (int'(ch_q) < NCH);
    assign ch_idx = ch_ok ? ch_q : '0;

    always_comb begin
        op  = x0_q;
        cf  = active_q[B0];
        neg = 1'b0;
        case (k_q)
            B0: begin op = x0_q;          cf = active_q[B0];             end
            B1: begin op = x1_q[ch_idx];  cf = active_q[B1];             end
            B2: begin op = x2_q[ch_idx];  cf = active_q[B2];             end
            A1: begin op = y1_q[ch_idx];  cf = active_q[A1]; neg = 1'b1; end
            A2: begin op = y2_q[ch_idx];  cf = active_q[A2]; neg = 1'b1; end
            default: ;
        endcase
    end

    assign prod     = op * cf;
    assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    assign acc_d    = neg ? (acc_q - prod_ext) : (acc_q + prod_ext);

    biquad_round_sat #(
        .ACC_W  (ACC_W),
        .DATA_W (DATA_W),
        .FRAC   (FRAC)
    ) u_round_sat (
        .acc_i  (acc_q),
        .data_o (rs_data),
        .sat_o  (rs_sat)
    );

    // A write in the same cycle as a commit must land in the copied bank.
    always_comb begin
        for (int i = 0; i < NCOEF; i++) begin
            shadow_d[i] = shadow_q[i];
        end
        if (coef_we && (int'(coef_addr) < NCOEF)) begin
            shadow_d[coef_addr] = coef_data;
        end
    end

    assign commit_now = ((state_q == IDLE) && coef_commit) ||
                        ((state_q == WB) && (pending_q || coef_commit));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NCOEF; i++) begin
                shadow_q[i] <= COEFF_W'(reset_coef(i, FRAC));
                active_q[i] <= COEFF_W'(reset_coef(i, FRAC));
            end
            pending_q <= 1'b0;
        end else begin
            for (int i = 0; i < NCOEF; i++) begin
                shadow_q[i] <= shadow_d[i];
            end
            if (commit_now) begin
                for (int i = 0; i < NCOEF; i++) begin
                    active_q[i] <= shadow_d[i];
                end
            end
            pending_q <= commit_now ? 1'b0
                                    : (pending_q | (coef_commit && (state_q != IDLE)));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            k_q         <= B0;
            ch_q        <= '0;
            x0_q        <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                x1_q[i] <= '0;
                x2_q[i] <= '0;
                y1_q[i] <= '0;
                y2_q[i] <= '0;
            end
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (clear) begin
                        for (int i = 0; i < NCH; i++) begin
                            x1_q[i] <= '0;
                            x2_q[i] <= '0;
                            y1_q[i] <= '0;
                            y2_q[i] <= '0;
                        end
                    end
                    if (accept) begin
                        ch_q    <= in_ch;
                        x0_q    <= in_data;
                        acc_q   <= '0;
                        k_q     <= B0;
                        state_q <= MAC;
                    end
                end
                MAC: begin
                    acc_q <= acc_d;
                    if (k_q == A2) begin
                        state_q <= WB;
                    end else begin
                        k_q <= coef_idx_e'(k_q + 3'd1);
                    end
                end
                WB: begin
                    out_valid_q <= 1'b1;
                    out_ch_q    <= ch_q;
                    out_data_q  <= ch_ok ? rs_data : '0;
                    out_sat_q   <= ch_ok ? rs_sat : 1'b0;
                    if (ch_ok) begin
                        x2_q[ch_idx] <= x1_q[ch_idx];
                        x1_q[ch_idx] <= x0_q;
                        y2_q[ch_idx] <= y1_q[ch_idx];
                        y1_q[ch_idx] <= rs_data;
                    end
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_biquad_iir_mc.sv
// Directed-vector bench for biquad_iir_mc with hand-computed expected outputs.
module tb_biquad_iir_mc;

    localparam int DATA_W  = 16;
    localparam int COEFF_W = 18;
    localparam int FRAC    = 14;
    localparam int ACC_W   = 48;
    localparam int NCH     = 2;
    localparam int CH_W    = 1;

    logic                      clk = 1'b0;
    logic                      reset_n = 1'b0;
    logic                      in_valid = 1'b0;
    logic                      in_ready;
    logic [CH_W-1:0]           in_ch = '0;
    logic signed [DATA_W-1:0]  in_data = '0;
    logic                      out_valid;
    logic [CH_W-1:0]           out_ch;
    logic signed [DATA_W-1:0]  out_data;
    logic                      out_sat;
    logic                      coef_we = 1'b0;
    logic [2:0]                coef_addr = '0;
    logic signed [COEFF_W-1:0] coef_data = '0;
    logic                      coef_commit = 1'b0;
    logic                      clear = 1'b0;

    int nVec = 0;
    int nErr = 0;
    int cyc  = 0;

    biquad_iir_mc #(
        .DATA_W  (DATA_W),
        .COEFF_W (COEFF_W),
        .FRAC    (FRAC),
        .ACC_W   (ACC_W),
        .NCH     (NCH)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_ch       (in_ch),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ch      (out_ch),
        .out_data    (out_data),
        .out_sat     (out_sat),
        .coef_we     (coef_we),
        .coef_addr   (coef_addr),
        .coef_data   (coef_data),
        .coef_commit (coef_commit),
        .clear       (clear)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Sends one sample and waits for its result; can pulse commit or raise clear mid-flight.
    task automatic applyStimulus(input int ch, input int data, input int commitAt,
                                 input int clearAt,
                                 output logic signed [DATA_W-1:0] y, output logic sat,
                                 output logic [CH_W-1:0] och, output int lat,
                                 output int rdyLow, output int accCyc);
        int guard;
        @(negedge clk);
        in_ch    = CH_W'(ch);
        in_data  = DATA_W'(data);
        in_valid = 1'b1;
        guard = 0;
        while (!in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1;
        accCyc   = cyc;
        in_valid = 1'b0;
        rdyLow   = in_ready ? 0 : 1;
        lat      = 0;
        while (lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            if (out_valid) break;
            if (!in_ready) rdyLow++;
            coef_commit = (lat == commitAt);
            if (lat == clearAt) clear = 1'b1;
        end
        coef_commit = 1'b0;
        y   = out_data;
        sat = out_sat;
        och = out_ch;
        if (!out_valid) begin
            nVec++;
            nErr++;
            $display("[TB] FAIL timeout ch=%0d data=%0d: no out_valid within %0d cycles",
                     ch, data, lat);
        end
    endtask

    task automatic writeCoef(input int addr, input int val, input logic commit);
        @(negedge clk);
        coef_we     = 1'b1;
        coef_addr   = 3'(addr);
        coef_data   = COEFF_W'(val);
        coef_commit = commit;
        @(negedge clk);
        coef_we     = 1'b0;
        coef_commit = 1'b0;
    endtask

    // The last write shares its cycle with the commit.
    task automatic loadBank(input int b0, input int b1, input int b2, input int a1, input int a2);
        writeCoef(0, b0, 1'b0);
        writeCoef(1, b1, 1'b0);
        writeCoef(2, b2, 1'b0);
        writeCoef(3, a1, 1'b0);
        writeCoef(4, a2, 1'b1);
    endtask

    task automatic clearHist();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        nVec++; if (in_ready !== 1'b0) begin nErr++; $display("[TB] FAIL rst_in_ready got %b want 0", in_ready); end
        nVec++; if (out_valid !== 1'b0) begin nErr++; $display("[TB] FAIL rst_out_valid got %b want 0", out_valid); end
        nVec++; if (out_data !== 16'sd0) begin nErr++; $display("[TB] FAIL rst_out_data got %0d want 0", out_data); end
        nVec++; if (out_sat !== 1'b0) begin nErr++; $display("[TB] FAIL rst_out_sat got %b want 0", out_sat); end
        nVec++; if (out_ch !== 1'b0) begin nErr++; $display("[TB] FAIL rst_out_ch got %0d want 0", out_ch); end
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        nVec++; if (in_ready !== 1'b1) begin nErr++; $display("[TB] FAIL post_rst_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_passthrough();
        logic signed [DATA_W-1:0] y; logic sat; logic [CH_W-1:0] och;
        int lat, rl, ac;
        applyStimulus(0, 1234, -1, -1, y, sat, och, lat, rl, ac);
        nVec++; if (lat !== 6) begin nErr++; $display("[TB] FAIL pass_latency got %0d want 6", lat); end
        nVec++; if (y !== 16'sd1234) begin nErr++; $display("[TB] FAIL pass_data got %0d want 1234", y); end
        nVec++; if (och !== 1'b0) begin nErr++; $display("[TB] FAIL pass_ch got %0d want 0", och); end
        nVec++; if (sat !== 1'b0) begin nErr++; $display("[TB] FAIL pass_sat got %b want 0", sat); end
        nVec++; if (rl !== 6) begin nErr++; $display("[TB] FAIL pass_ready_low got %0d want 6", rl); end
        @(posedge clk);
        #1;
        nVec++; if (out_valid !== 1'b0) begin nErr++; $display("[TB] FAIL pass_valid_pulse got %b want 0", out_valid); end
    endtask

    task automatic test_fir();
        int xin [4] = '{16384, 0, 0, 0};
        int yexp [4] = '{4096, 4096, 4096, 0};
        logic signed [DATA_W-1:0] y; logic sat; logic [CH_W-1:0] och;
        int lat, rl, ac, prevAc;
        loadBank(4096, 4096, 4096, 0, 0);
        clearHist();
        prevAc = 0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, xin[i], -1, -1, y, sat, och, lat, rl, ac);
            nVec++; if (y !== 16'(yexp[i])) begin nErr++; $display("[TB] FAIL fir[%0d] got %0d want %0d", i, y, yexp[i]); end
            if (i > 0) begin
                nVec++; if (ac - prevAc !== 7) begin nErr++; $display("[TB] FAIL fir_throughput[%0d] got %0d want 7", i, ac - prevAc); end
            end
            prevAc = ac;
        end
    endtask

    task automatic test_recursion();
        int yexp [5] = '{1000, 500, 250, 125, 63};
        logic signed [DATA_W-1:0] y; logic sat; logic [CH_W-1:0] och;
        int lat, rl, ac;
        loadBank(16384, 0, 0, -8192, 0);
        clearHist();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, (i == 0) ? 1000 : 0, -1, -1, y, sat, och, lat, rl, ac);
            nVec++; if (y !== 16'(yexp[i])) begin nErr++; $display("[TB] FAIL rec[%0d] got %0d want %0d", i, y, yexp[i]); end
        end
    endtask

    task automatic test_saturation();
        int xin [3] = '{30000, -30000, 100};
        int yexp [3] = '{32767, -32768, 200};
        logic sexp [3] = '{1'b1, 1'b1, 1'b0};
        logic signed [DATA_W-1:0] y; logic sat; logic [CH_W-1:0] och;
        int lat, rl, ac;
        loadBank(32768, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, xin[i], -1, -1, y, sat, och, lat, rl, ac);
            nVec++; if (y !== 16'(yexp[i])) begin nErr++; $display("[TB] FAIL sat_data[%0d] got %0d want %0d", i, y, yexp[i]); end
            nVec++; if (sat !== sexp[i]) begin nErr++; $display("[TB] FAIL sat_flag[%0d] got %b want %b", i, sat, sexp[i]); end
        end
    endtask

    task automatic test_channels();
        int yexp0 [4] = '{1000, 500, 250, 125};
        logic signed [DATA_W-1:0] y; logic sat; logic [CH_W-1:0] och;
        int lat, rl, ac;
        loadBank(16384, 0, 0, -8192, 0);
        clearHist();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, (i == 0) ? 1000 : 0, -1, -1, y, sat, och, lat, rl, ac);
            nVec++; if (y !== 16'(yexp0[i])) begin nErr++; $display("[TB] FAIL chan0[%0d] got %0d want %0d", i, y, yexp0[i]); end
            nVec++; if (och !== 1'b0) begin nErr++; $display("[TB] FAIL chan0_id[%0d] got %0d want 0", i, och); end
            applyStimulus(1, 0, -1, -1, y, sat, och, lat, rl, ac);
            nVec++; if (y !== 16'sd0) begin nErr++; $display("[TB] FAIL chan1[%0d] got %0d want 0", i, y); end
            nVec++; if (och !== 1'b1) begin nErr++; $display("[TB] FAIL chan1_id[%0d] got %0d want 1", i, och); end
        end
    endtask

    task automatic test_commit_busy();
        logic signed [DATA_W-1:0] y; logic sat; logic [CH_W-1:0] och;
        int lat, rl, ac;
        loadBank(16384, 0, 0, 0, 0);
        clearHist();
        writeCoef(0, 32768, 1'b0);
        applyStimulus(0, 100, 2, -1, y, sat, och, lat, rl, ac);
        nVec++; if (y !== 16'sd100) begin nErr++; $display("[TB] FAIL commit_old_bank got %0d want 100", y); end
        applyStimulus(0, 100, -1, -1, y, sat, och, lat, rl, ac);
        nVec++; if (y !== 16'sd200) begin nErr++; $display("[TB] FAIL commit_new_bank got %0d want 200", y); end
    endtask

    task automatic test_clear_busy();
        logic signed [DATA_W-1:0] y; logic sat; logic [CH_W-1:0] och;
        int lat, rl, ac;
        loadBank(16384, 0, 0, -8192, 0);
        clearHist();
        applyStimulus(0, 1000, -1, -1, y, sat, och, lat, rl, ac);
        nVec++; if (y !== 16'sd1000) begin nErr++; $display("[TB] FAIL clr_first got %0d want 1000", y); end
        applyStimulus(0, 0, -1, 2, y, sat, och, lat, rl, ac);
        nVec++; if (y !== 16'sd500) begin nErr++; $display("[TB] FAIL clr_held_off got %0d want 500", y); end
        nVec++; if (in_ready !== 1'b0) begin nErr++; $display("[TB] FAIL clr_in_ready got %b want 0", in_ready); end
        @(posedge clk);
        #1;
        clear = 1'b0;
        applyStimulus(0, 0, -1, -1, y, sat, och, lat, rl, ac);
        nVec++; if (y !== 16'sd0) begin nErr++; $display("[TB] FAIL clr_applied got %0d want 0", y); end
    endtask

    task automatic test_reset_abort();
        logic signed [DATA_W-1:0] y; logic sat; logic [CH_W-1:0] och;
        int lat, rl, ac, seen;
        loadBank(32768, 0, 0, 0, 0);
        @(negedge clk);
        in_ch    = 1'b0;
        in_data  = 16'sd5000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        nVec++; if (in_ready !== 1'b0) begin nErr++; $display("[TB] FAIL abort_in_ready got %b want 0", in_ready); end
        seen = 0;
        repeat (2) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        nVec++; if (seen !== 0) begin nErr++; $display("[TB] FAIL abort_no_valid got %0d strobes want 0", seen); end
        applyStimulus(0, 1234, -1, -1, y, sat, och, lat, rl, ac);
        nVec++; if (y !== 16'sd1234) begin nErr++; $display("[TB] FAIL abort_passthrough got %0d want 1234", y); end
    endtask

    initial begin
        $display("[TB] starting biquad_iir_mc directed tests");
        test_reset();
        test_passthrough();
        test_fir();
        test_recursion();
        test_saturation();
        test_channels();
        test_commit_busy();
        test_clear_busy();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

endmodule

// File: doc/biquad_iir_mc.md
Name: biquad_iir_mc

Overview:
- Parametrised, multi-channel, second-order IIR (biquad) section; successor to the fixed-coefficient lowpass.
- Runtime-loadable signed coefficients, one time-multiplexed multiplier shared by all channels, valid/ready input handshake, round-and-saturate output.
- Sits between the audio sample source and downstream EQ stages; cascade instances for higher orders.

Parameters:
DATA_W, 16, sample width (signed two's complement)
COEFF_W, 18, coefficient width (signed)
FRAC, 14, coefficient fractional bits (1.0 = 2**FRAC)
ACC_W, 48, accumulator width (signed)
NCH, 2, channel count; history kept per channel

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  input sample valid
in_ready  out  1  block can accept a sample
in_ch  in  max(1,$clog2(NCH))  channel of input sample
in_data  in  DATA_W  signed input sample
out_valid  out  1  one-cycle result strobe
out_ch  out  max(1,$clog2(NCH))  channel of result
out_data  out  DATA_W  signed filtered sample
out_sat  out  1  result was clipped (qualified by out_valid)
coef_we  in  1  write shadow coefficient
coef_addr  in  3  0=b0 1=b1 2=b2 3=a1 4=a2; 5-7 ignored
coef_data  in  COEFF_W  shadow coefficient value
coef_commit  in  1  pulse: copy shadow bank to active bank
clear  in  1  zero all channel history

Behaviour:
- Equation: y = b0*x0 + b1*x1 + b2*x2 - a1*y1 - a2*y2, per channel; coefficients shared across channels.
- Reset values: in_ready=0 during reset and 1 in the first cycle after release; out_valid=0, out_ch=0, out_data=0, out_sat=0; all history 0; active and shadow banks: b0=2**FRAC, all others 0 (passthrough); commit-pending=0.
- FSM states: IDLE, MAC, WB.
  - IDLE: in_ready=1 unless clear=1. An accept (in_valid & in_ready) at an edge latches ch/x0, clears acc, k=0, goes to MAC.
  - MAC: in_ready=0. Each edge adds product k (order b0x0, b1x1, b2x2, -a1y1, -a2y2) to acc. After the 5th MAC edge, go to WB.
  - WB: one edge performs round-half-up (acc + 2**(FRAC-1), arithmetic shift right FRAC), saturates to [-2**(DATA_W-1), 2**(DATA_W-1)-1], registers out_data/out_ch/out_sat, pulses out_valid, updates channel history (x2<=x1, x1<=x0, y2<=y1, y1<=saturated y), then returns to IDLE.
- Latency: out_valid is high in the cycle beginning 6 edges after the accepting edge, for exactly 1 cycle. Throughput: 1 sample per 7 cycles.
- Products are full-precision DATA_W+COEFF_W signed, sign-extended to ACC_W. The accumulator does not wrap for default widths; no intermediate saturation.
- Coefficient path:
  - coef_we writes the shadow bank at any time.
  - coef_commit in IDLE copies shadow to active at that edge.
  - coef_commit while busy sets commit-pending; the copy happens at the WB edge, so the in-flight sample uses the old bank throughout.
  - Simultaneous coef_we and coef_commit: the write lands first and is included in the commit.
- clear:
  - Honoured only in IDLE: zeros all history at that edge. in_ready is 0 while clear=1, so there is no accept in the same cycle.
  - If clear is asserted while busy, it is held off; it takes effect once the FSM returns to IDLE, provided clear is still asserted.
- in_ch >= NCH: sample is accepted and out_valid is produced with out_data=0 and out_sat=0; no history is modified.
- reset_n asserted mid-computation: aborts immediately to reset values; no out_valid is produced for the aborted sample.
- in_valid while busy: not accepted; the sender holds the sample.

Decomposition:
- Package biquad_pkg:
  - state enum (IDLE, MAC, WB)
  - coefficient index enum (B0..A2)
  - localparam ONE = 2**FRAC helper
  - reset-bank constants
- Sub-module biquad_round_sat: combinational round-half-up, shift and saturate (ACC_W in; DATA_W out plus sat flag). Reused by the later EQ stages.

Test Plan (defaults: DATA_W=16, FRAC=14):
- Reset release, passthrough bank: ch0 input 1234 accepted -> out_valid exactly 6 edges later, out_data=1234, out_ch=0, out_sat=0; in_ready low for those 6 cycles.
- FIR taps: b0=b1=b2=4096 (0.25), a=0, commit. Impulse 16384 then 0,0,0 on ch0 -> outputs 4096, 4096, 4096, 0.
- Recursion: b0=16384, a1=-8192 (+0.5*y1), others 0. Impulse 1000 then zeros -> 1000, 500, 250, 125, 63 (round half up).
- Saturation: b0=32768 (2.0), a=0. Input 30000 -> 32767, out_sat=1; input -30000 -> -32768, out_sat=1; input 100 -> 200, out_sat=0.
- Channel isolation (NCH=2, recursion bank): alternating ch0 impulse 1000 and ch1 zeros -> ch1 outputs all 0; ch0 sequence matches the single-channel case.
- Control corners:
  - coef_commit pulsed during MAC: current sample uses the old bank, next sample uses the new bank.
  - clear asserted while busy: history cleared only after WB, in IDLE.
  - reset_n dropped during MAC: no out_valid; first post-reset sample gives passthrough.
